// File: rtl/led_anim_seq_if.sv
// Control, pattern-write and display-drive signals of the LED animation sequencer.
interface led_anim_seq_if #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned FRAMES     = 32,
  parameter int unsigned SEG_W      = 7,
  parameter int unsigned PRESCALE_W = 24
);
  localparam int unsigned FW = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                    start;
  logic                    stop;
  logic [1:0]              mode;
  logic [PRESCALE_W-1:0]   div;
  logic [FW-1:0]           last_frame;
  logic                    wr_en;
  logic [CW-1:0]           wr_ch;
  logic [FW-1:0]           wr_frame;
  logic [SEG_W-1:0]        wr_data;
  logic [NUM_CH*SEG_W-1:0] seg;
  logic [FW-1:0]           frame;
  logic                    busy;
  logic                    done;

  modport master (
    output start, stop, mode, div, last_frame, wr_en, wr_ch, wr_frame, wr_data,
    input  seg, frame, busy, done
  );

  modport slave (
    input  start, stop, mode, div, last_frame, wr_en, wr_ch, wr_frame, wr_data,
    output seg, frame, busy, done
  );
endinterface

// File: rtl/led_anim_seq.sv
// Multi-digit 7-segment animation sequencer: pattern memory walked by a
// prescaled frame counter in loop, ping-pong, one-shot or reverse mode.
module led_anim_seq #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned FRAMES     = 32,
  parameter int unsigned SEG_W      = 7,
  parameter int unsigned PRESCALE_W = 24
) (
  input  logic            clk,
  input  logic            rst,
  led_anim_seq_if.slave   bus
);
  localparam int unsigned FW = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int unsigned SW = NUM_CH * SEG_W;

  localparam logic [1:0] MODE_LOOP = 2'b00;
  localparam logic [1:0] MODE_PING = 2'b01;
  localparam logic [1:0] MODE_ONE  = 2'b10;
  localparam logic [1:0] MODE_REV  = 2'b11;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state, state_next;
  logic [FW-1:0]         frame_q, frame_next;
  logic [FW-1:0]         last_q, last_next, last_clamped;
  logic [PRESCALE_W-1:0] count_q, count_next;
  logic [PRESCALE_W-1:0] div_q, div_next;
  logic [1:0]            mode_q, mode_next;
  logic                  dir_up_q, dir_up_next;
  logic                  show_q, show_next;
  logic                  busy_q, busy_next;
  logic                  done_q, done_next;
  logic [SW-1:0]         seg_q, seg_next;
  logic [SW-1:0]         mem_rd;

  logic [SEG_W-1:0] mem [NUM_CH][FRAMES];

  // Pattern memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (bus.wr_en && (32'(bus.wr_ch) < NUM_CH) && (32'(bus.wr_frame) < FRAMES)) begin
      mem[bus.wr_ch][bus.wr_frame] <= bus.wr_data;
    end
  end

  // Read every channel's pattern for the current frame.
  always_comb begin
    mem_rd = '1;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      mem_rd[c*SEG_W +: SEG_W] = mem[c][frame_q];
    end
  end

  // Out-of-range last frame requests play the whole memory.
  always_comb begin
    last_clamped = bus.last_frame;
    if (32'(bus.last_frame) >= FRAMES) begin
      last_clamped = FW'(FRAMES - 1);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, prescaler and frame-advance logic; stop beats start.
  always_comb begin
    state_next  = state;
    frame_next  = frame_q;
    last_next   = last_q;
    count_next  = count_q;
    div_next    = div_q;
    mode_next   = mode_q;
    dir_up_next = dir_up_q;
    show_next   = show_q;
    busy_next   = busy_q;
    done_next   = 1'b0;

    if (bus.stop) begin
      state_next = IDLE;
      busy_next  = 1'b0;
      show_next  = 1'b0;
    end else if (bus.start) begin
      state_next  = RUN;
      mode_next   = bus.mode;
      div_next    = bus.div;
      last_next   = last_clamped;
      count_next  = '0;
      dir_up_next = 1'b1;
      frame_next  = (bus.mode == MODE_REV) ? last_clamped : '0;
      busy_next   = 1'b1;
      show_next   = 1'b1;
    end else if (state == RUN) begin
      if (count_q == div_q) begin
        count_next = '0;
        case (mode_q)
          MODE_LOOP: frame_next = (frame_q == last_q) ? '0 : frame_q + FW'(1);
          MODE_REV:  frame_next = (frame_q == '0) ? last_q : frame_q - FW'(1);
          MODE_PING: begin
            if (last_q != '0) begin
              if (dir_up_q) begin
                if (frame_q == last_q) begin
                  frame_next  = frame_q - FW'(1);
                  dir_up_next = 1'b0;
                end else begin
                  frame_next = frame_q + FW'(1);
                end
              end else begin
                if (frame_q == '0) begin
                  frame_next  = FW'(1);
                  dir_up_next = 1'b1;
                end else begin
                  frame_next = frame_q - FW'(1);
                end
              end
            end
          end
          MODE_ONE: begin
            if (frame_q == last_q) begin
              state_next = IDLE;
              busy_next  = 1'b0;
              done_next  = 1'b1;
            end else begin
              frame_next = frame_q + FW'(1);
            end
          end
          default: frame_next = frame_q;
        endcase
      end else begin
        count_next = count_q + PRESCALE_W'(1);
      end
    end

    seg_next = show_next ? mem_rd : '1;
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q  <= '0;
      last_q   <= '0;
      count_q  <= '0;
      div_q    <= '0;
      mode_q   <= MODE_LOOP;
      dir_up_q <= 1'b1;
      show_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      seg_q    <= '1;
    end else begin
      frame_q  <= frame_next;
      last_q   <= last_next;
      count_q  <= count_next;
      div_q    <= div_next;
      mode_q   <= mode_next;
      dir_up_q <= dir_up_next;
      show_q   <= show_next;
      busy_q   <= busy_next;
      done_q   <= done_next;
      seg_q    <= seg_next;
    end
  end

  assign bus.seg   = seg_q;
  assign bus.frame = frame_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
endmodule

// File: tb/tb_led_anim_seq.sv
// Bench for led_anim_seq: directed scenarios then randomized playback,
// compared each cycle against a time-based reference model.
module tb_led_anim_seq;
  localparam int unsigned NUM_CH     = 4;
  localparam int unsigned FRAMES     = 20;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned PRESCALE_W = 8;
  localparam int unsigned FW         = 5;
  localparam int unsigned SW         = NUM_CH * SEG_W;

  logic clk;
  logic rst;

  led_anim_seq_if #(.NUM_CH(NUM_CH), .FRAMES(FRAMES), .SEG_W(SEG_W),
                    .PRESCALE_W(PRESCALE_W)) bus ();

  led_anim_seq #(.NUM_CH(NUM_CH), .FRAMES(FRAMES), .SEG_W(SEG_W),
                 .PRESCALE_W(PRESCALE_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // Reference model: playback position derived from time since start.
  logic [SEG_W-1:0] mem [NUM_CH][FRAMES];
  bit               m_run;
  bit               m_show;
  bit               m_done;
  int               m_t;
  int               m_mode;
  int               m_div;
  int               m_L;
  int               m_frame;
  logic [SW-1:0]    m_seg;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame shown after k advances in each mode.
  function automatic int frame_at(input int mode, input int lf, input int k);
    int p;
    case (mode)
      0: return k % (lf + 1);
      1: begin
        if (lf == 0) return 0;
        p = k % (2 * lf);
        return (p <= lf) ? p : 2 * lf - p;
      end
      2: return k;
      default: return lf - (k % (lf + 1));
    endcase
  endfunction

  // One clock: update model from the driven inputs, then compare all outputs.
  task automatic tick();
    bit               s_rst, s_start, s_stop, s_wr;
    int               s_mode, s_div, s_lf, s_ch, s_wf, k;
    logic [SEG_W-1:0] s_wd;
    logic [SW-1:0]    rd;
    s_rst   = rst;
    s_start = bus.start;
    s_stop  = bus.stop;
    s_wr    = bus.wr_en;
    s_mode  = int'(bus.mode);
    s_div   = int'(bus.div);
    s_lf    = int'(bus.last_frame);
    s_ch    = int'(bus.wr_ch);
    s_wf    = int'(bus.wr_frame);
    s_wd    = bus.wr_data;
    for (int c = 0; c < int'(NUM_CH); c++) rd[c*SEG_W +: SEG_W] = mem[c][m_frame];
    @(posedge clk);
    m_done = 1'b0;
    if (s_rst) begin
      m_run = 1'b0; m_show = 1'b0; m_frame = 0; m_seg = '1;
    end else if (s_stop) begin
      m_run = 1'b0; m_show = 1'b0; m_seg = '1;
    end else if (s_start) begin
      m_mode  = s_mode;
      m_div   = s_div;
      m_L     = (s_lf > int'(FRAMES) - 1) ? int'(FRAMES) - 1 : s_lf;
      m_t     = 0;
      m_run   = 1'b1;
      m_show  = 1'b1;
      m_seg   = rd;
      m_frame = (m_mode == 3) ? m_L : 0;
    end else begin
      m_seg = m_show ? rd : '1;
      if (m_run) begin
        m_t++;
        k = m_t / (m_div + 1);
        if (m_mode == 2 && k > m_L) begin
          m_run  = 1'b0;
          m_done = 1'b1;
        end else begin
          m_frame = frame_at(m_mode, m_L, k);
        end
      end
    end
    if (s_wr) mem[s_ch][s_wf] = s_wd;
    #1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.wr_en = 1'b0;
    check("frame", 64'(bus.frame), 64'(m_frame));
    check("busy",  64'(bus.busy),  64'(m_run));
    check("done",  64'(bus.done),  64'(m_done));
    check("seg",   64'(bus.seg),   64'(m_seg));
  endtask

  task automatic do_start(input int mode, input int dv, input int lf);
    bus.mode       = 2'(mode);
    bus.div        = PRESCALE_W'(dv);
    bus.last_frame = FW'(lf);
    bus.start      = 1'b1;
  endtask

  task automatic do_write(input int ch, input int fr, input logic [SEG_W-1:0] d);
    bus.wr_en    = 1'b1;
    bus.wr_ch    = 2'(ch);
    bus.wr_frame = FW'(fr);
    bus.wr_data  = d;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_run = 1'b0; m_show = 1'b0; m_done = 1'b0; m_frame = 0; m_seg = '1;
    m_t = 0; m_mode = 0; m_div = 0; m_L = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0; bus.mode = 2'b00; bus.div = '0;
    bus.last_frame = '0; bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_frame = '0;
    bus.wr_data = '0;

    // Reset state
    tick();
    tick();
    check("reset_seg_blank", 64'(bus.seg), 64'({SW{1'b1}}));
    rst = 1'b0;

    // Preload whole memory; ch0 frames 0..3 get the known ramp
    for (int c = 0; c < int'(NUM_CH); c++)
      for (int f = 0; f < int'(FRAMES); f++) begin
        do_write(c, f, SEG_W'($urandom));
        tick();
      end
    do_write(0, 0, 7'h7F); tick();
    do_write(0, 1, 7'h77); tick();
    do_write(0, 2, 7'h73); tick();
    do_write(0, 3, 7'h71); tick();

    // Loop, div=2, last=3
    do_start(0, 2, 3);
    tick();
    check("loop_first_frame", 64'(bus.frame), 64'(0));
    for (int i = 0; i < 16; i++) tick();

    // Ping-pong, div=0, last=2
    do_start(1, 0, 2);
    for (int i = 0; i < 9; i++) tick();

    // One-shot, div=1, last=3; done on the 9th cycle after start
    do_start(2, 1, 3);
    for (int i = 0; i < 8; i++) tick();
    check("oneshot_busy_before", 64'(bus.busy), 64'(1));
    tick();
    check("oneshot_done", 64'(bus.done), 64'(1));
    check("oneshot_frame", 64'(bus.frame), 64'(3));
    for (int i = 0; i < 3; i++) tick();
    check("oneshot_hold_seg", 64'(bus.seg[6:0]), 64'(7'h71));

    // Reverse with clamp: 25 -> 19
    do_start(3, 0, 25);
    tick();
    check("rev_clamp_start", 64'(bus.frame), 64'(19));
    for (int i = 0; i < 24; i++) tick();

    // Stop, then start+stop collision stays idle
    bus.stop = 1'b1; tick();
    check("stop_blank", 64'(bus.seg), 64'({SW{1'b1}}));
    do_start(0, 0, 3); bus.stop = 1'b1; tick();
    check("collision_idle", 64'(bus.busy), 64'(0));
    tick();

    // Live write to the displayed frame during RUN
    do_start(0, 7, 3);
    tick(); tick(); tick();
    do_write(1, m_frame, 7'h2A); tick();
    tick();
    check("live_write_seg", 64'(bus.seg[13:7]), 64'(7'h2A));
    for (int i = 0; i < 4; i++) tick();
    bus.stop = 1'b1; tick();
    check("midrun_stop_nodone", 64'(bus.done), 64'(0));
    tick();

    // Reset mid-run, memory retained on replay
    do_start(0, 1, 3);
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_midrun_frame", 64'(bus.frame), 64'(0));
    do_start(0, 0, 3);
    for (int i = 0; i < 3; i++) tick();
    check("replay_ch0", 64'(bus.seg[6:0]), 64'(7'h77));
    for (int i = 0; i < 6; i++) tick();

    // Randomized playback with random writes, stops and restarts
    for (int e = 0; e < 40; e++) begin
      int n;
      do_start(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 31)));
      tick();
      n = int'($urandom_range(10, 60));
      for (int i = 0; i < n; i++) begin
        int r;
        if ($urandom_range(0, 3) == 0)
          do_write(int'($urandom_range(0, 3)), int'($urandom_range(0, FRAMES - 1)),
                   SEG_W'($urandom));
        r = int'($urandom_range(0, 99));
        if (r < 3) bus.stop = 1'b1;
        else if (r < 6)
          do_start(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 31)));
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/led_anim_seq.md
Name: led_anim_seq

Overview:
Parametrised LED animation sequencer for multi-digit 7-segment displays. It holds a writable pattern memory of NUM_CH channels by FRAMES frames, each entry SEG_W bits, active-low. A prescaler sets the frame rate and a frame counter walks the memory in one of four modes (loop, ping-pong, one-shot, reverse loop). It replaces fixed per-digit frame-to-pattern decoders and drives the display pins directly with registered outputs.

Parameters:
NUM_CH, 4, number of display digits / channels
FRAMES, 32, frames per animation; FW = $clog2(FRAMES)
SEG_W, 7, segment bits per channel, active-low (0 = lit)
PRESCALE_W, 24, width of the frame-period divider

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; (re)starts playback
stop  in  1  one-cycle pulse; aborts playback, blanks display
mode  in  2  00 loop, 01 ping-pong, 10 one-shot, 11 reverse loop; sampled on start
div  in  PRESCALE_W  frame period = div+1 clk cycles; sampled on start
last_frame  in  FW  highest frame played (0..last_frame); sampled on start
wr_en  in  1  pattern memory write strobe
wr_ch  in  max(1,$clog2(NUM_CH))  channel to write
wr_frame  in  FW  frame to write
wr_data  in  SEG_W  pattern to write, active-low
seg  out  NUM_CH*SEG_W  segment outputs; channel c at bits [c*SEG_W +: SEG_W]
frame  out  FW  current frame index
busy  out  1  high while in RUN
done  out  1  one-cycle pulse at one-shot completion

Behaviour:
- Reset: state IDLE, frame=0, prescaler count=0, busy=0, done=0, direction=up, seg=all ones (blank). Pattern memory is not reset; it retains its contents through rst.
- States: IDLE, RUN. IDLE->RUN on start. RUN->IDLE on stop, or at the end of a one-shot. start in RUN restarts: all inputs are resampled and count is cleared.
- start and stop in the same cycle: stop wins.
- On start (cycle N):
  - Latch mode, div and last_frame. A last_frame value >= FRAMES clamps to FRAMES-1.
  - count=0. frame becomes 0 (modes 00/01/10) or last_frame (mode 11) at N+1. busy=1 from N+1.
- Prescaler: in RUN, count increments every cycle. When count==div_r, count goes to 0 and frame advances. Each frame is held exactly div+1 cycles; div=0 advances every cycle.
- Advance rules (L = latched last_frame):
  - Loop: 0..L, then wraps to 0.
  - Reverse: L..0, then wraps to L.
  - Ping-pong: up to L, flip, down to 0, flip. Endpoints appear once per turn (0,1,..,L,L-1,..,0,1,...).
  - One-shot: 0..L. When frame L's period expires: done=1 for one cycle, busy=0, state IDLE, frame stays L, seg keeps showing frame L.
  - L=0 in any repeating mode: frame stays 0 and the prescaler keeps running.
- seg timing: registered memory read of the current frame for all channels. seg reflects frame with 1-cycle latency (frame changes at cycle M, seg shows it at M+1).
- IDLE display: seg is blank after reset or stop. After a one-shot completes, seg holds the last pattern until the next start, stop or rst.
- Memory writes:
  - Accepted in any state.
  - A write at cycle M is visible on seg by M+2 if it targets the displayed frame. Read-before-write on the same cycle.
  - Writes never disturb the frame, count or state.
- stop in RUN: state IDLE, busy=0, seg blank on the next cycle, frame holds its value. No done pulse.
- rst mid-operation: same as power-on reset, effective at the next edge; memory is preserved.

Test Plan:
- Loop timing: write ch0 frames 0..3 = 7'h7F, 7'h77, 7'h73, 7'h71; mode=00, div=2, last_frame=3, start -> frame sequence 0,1,2,3,0, each held 3 cycles; seg[6:0] follows with 1-cycle lag; busy=1 throughout.
- Ping-pong: mode=01, div=0, last_frame=2 -> frame 0,1,2,1,0,1,2 on consecutive cycles.
- One-shot: mode=10, div=1, last_frame=3, start at cycle 0 -> frames 0..3 each held 2 cycles over cycles 1-8; done=1 only at cycle 9 with busy=0 the same cycle; frame stays 3; seg holds pattern 7'h71.
- Reverse with clamp: FRAMES=20, mode=11, last_frame=25 -> frame starts at 19 and decrements to 0, then wraps to 19.
- Stop/start collision and live write: start+stop in the same cycle -> stays IDLE; mid-run stop -> seg all ones next cycle, no done; a write to the displayed frame during RUN appears on seg within 2 cycles.
- Reset mid-run: assert rst during loop playback -> next cycle frame=0, busy=0, seg blank; a new start replays the previously written patterns unchanged.
